// File: rtl/hmj_ld_pkg.sv
// hmj_ld_pkg: shared state encodings, mode codes and data width
// for the dual-radar measurement scheduler.
package hmj_ld_pkg;

  localparam int DW = 20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    REQ       = 2'd2,
    WAIT_RSP  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RR   = 2'd0;
  localparam logic [1:0] MODE_R1   = 2'd1;
  localparam logic [1:0] MODE_R2   = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

endpackage

// File: rtl/hmj_ld_tick_gen.sv
// hmj_ld_tick_gen: enable-gated slot period counter.
// Emits a single-cycle tick on the last count of each period.
module hmj_ld_tick_gen #(
  parameter int PERIOD_CYC = 5_000_000,
  localparam int CW = $clog2(PERIOD_CYC)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(PERIOD_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hmj_ld_scheduler.sv
// hmj_ld_scheduler: time-slotted request sequencer for two radar
// front ends, with response latch, link-fault tracking and alarm.
module hmj_ld_scheduler
  import hmj_ld_pkg::*;
#(
  parameter int DW          = hmj_ld_pkg::DW,
  parameter int PERIOD_CYC  = 5_000_000,
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int MISS_MAX    = 3,
  parameter int NEAR_MIN    = 3,
  parameter int NEAR_MAX    = 35
) (
  input  logic          i_sys_clk,
  input  logic          i_sys_rst_n,
  input  logic          i_en,
  input  logic [1:0]    i_mode,
  output logic [1:0]    o_req,
  input  logic [1:0]    i_vld,
  input  logic [DW-1:0] i_jl1,
  input  logic [DW-1:0] i_jl2,
  input  logic [DW-1:0] i_sd1,
  input  logic [DW-1:0] i_sd2,
  output logic [DW-1:0] o_jl,
  output logic [DW-1:0] o_sd,
  output logic          o_src,
  output logic          o_upd,
  output logic [1:0]    o_fault,
  output logic          o_alarm,
  output logic          o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  state_t        state;
  state_t        state_nxt;
  logic          tick;
  logic          issue;
  logic          accept;
  logic          tmo;
  logic          tgt;
  logic          tgt_sel;
  logic          rr_ptr;
  logic [TW-1:0] tcnt;
  logic [MW-1:0] miss [2];
  logic [DW-1:0] last_jl [2];
  logic [DW-1:0] jl_sel;
  logic [DW-1:0] sd_sel;
  logic [1:0]    near;

  hmj_ld_tick_gen #(
    .PERIOD_CYC(PERIOD_CYC)
  ) u_tick (
    .clk  (i_sys_clk),
    .rst_n(i_sys_rst_n),
    .en   (i_en),
    .tick (tick)
  );

  assign jl_sel = tgt ? i_jl2 : i_jl1;
  assign sd_sel = tgt ? i_sd2 : i_sd1;
  assign o_busy = (state == REQ) || (state == WAIT_RSP);

  // A faulted link cannot raise the alarm from its stale distance.
  assign near[0] = !o_fault[0]
                && (last_jl[0] > DW'(NEAR_MIN))
                && (last_jl[0] < DW'(NEAR_MAX));
  assign near[1] = !o_fault[1]
                && (last_jl[1] > DW'(NEAR_MIN))
                && (last_jl[1] < DW'(NEAR_MAX));

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    accept    = 1'b0;
    tmo       = 1'b0;
    tgt_sel   = rr_ptr;
    unique case (1'b1)
      (i_mode == MODE_R1): tgt_sel = 1'b0;
      (i_mode == MODE_R2): tgt_sel = 1'b1;
      default:             tgt_sel = rr_ptr;
    endcase
    unique case (state)
      IDLE: begin
        if (i_en) state_nxt = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!i_en) begin
          state_nxt = IDLE;
        end else if (tick && (i_mode != MODE_HOLD)) begin
          issue     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        // A frame landing on the timeout cycle still counts.
        accept = i_vld[tgt];
        tmo    = !accept
              && (tcnt == TW'(TIMEOUT_CYC - 1));
        if (accept || tmo) begin
          state_nxt = i_en ? WAIT_TICK : IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      o_req      <= 2'b00;
      o_jl       <= '0;
      o_sd       <= '0;
      o_src      <= 1'b0;
      o_upd      <= 1'b0;
      o_fault    <= 2'b00;
      o_alarm    <= 1'b0;
      tgt        <= 1'b0;
      rr_ptr     <= 1'b0;
      tcnt       <= '0;
      miss[0]    <= '0;
      miss[1]    <= '0;
      last_jl[0] <= '0;
      last_jl[1] <= '0;
    end else begin
      o_req   <= 2'b00;
      o_upd   <= accept;
      o_alarm <= |near;
      if (issue) begin
        o_req <= tgt_sel ? 2'b10 : 2'b01;
        tgt   <= tgt_sel;
        if (i_mode == MODE_RR) rr_ptr <= ~rr_ptr;
      end
      if (state == REQ) begin
        tcnt <= '0;
      end else if (state == WAIT_RSP) begin
        tcnt <= tcnt + 1'b1;
      end
      if (accept) begin
        o_jl         <= jl_sel;
        o_sd         <= sd_sel;
        o_src        <= tgt;
        miss[tgt]    <= '0;
        o_fault[tgt] <= 1'b0;
        last_jl[tgt] <= jl_sel;
      end
      if (tmo) begin
        if (miss[tgt] != MW'(MISS_MAX)) begin
          miss[tgt] <= miss[tgt] + 1'b1;
        end
        if (miss[tgt] >= MW'(MISS_MAX - 1)) begin
          o_fault[tgt] <= 1'b1;
        end
      end
    end
  end

endmodule
